// File: rtl/ring_sequence_checker_pkg.sv
// Shared definitions for the ring sequence checker: state encoding and default ring width.
package ring_sequence_checker_pkg;

    localparam int RING_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOCK  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/ring_sequence_checker_onehot_index.sv
// Combinational one-hot decoder: reports whether q has exactly one hot bit and its index.
module onehot_index #(
    parameter int WIDTH = 4,
    localparam int PH_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic [PH_W-1:0]  idx,
    output logic             is_onehot
);

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q[i]) idx = PH_W'(i);
        end
    end

    // idx is only meaningful when is_onehot is high.
    assign is_onehot = ($countones(q) == 1);

endmodule

// File: rtl/ring_sequence_checker.sv
// Monitors a one-hot ring counter: tracks phase, counts revolutions, latches sticky faults.
module ring_sequence_checker
    import ring_sequence_checker_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH_DEF,
    parameter int REV_W = 8,
    localparam int PH_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             resync,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] q_in,
    output logic [PH_W-1:0]  phase,
    output logic             phase_valid,
    output logic             wrap_pulse,
    output logic [REV_W-1:0] rev_count,
    output logic             err_onehot,
    output logic             err_seq,
    output logic             in_fault
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  prev_q, prev_d;
    logic [PH_W-1:0]   phase_d;
    logic [REV_W-1:0]  rev_d;
    logic              eoh_d, eseq_d, wrap_d;
    logic [WIDTH-1:0]  exp_q;
    logic [PH_W-1:0]   hot_idx;
    logic              hot_ok;

    onehot_index #(.WIDTH(WIDTH)) u_dec (
        .q         (q_in),
        .idx       (hot_idx),
        .is_onehot (hot_ok)
    );

    assign exp_q = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            phase       <= '0;
            rev_count   <= '0;
            err_onehot  <= 1'b0;
            err_seq     <= 1'b0;
            wrap_pulse  <= 1'b0;
            phase_valid <= 1'b0;
            in_fault    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            phase       <= phase_d;
            rev_count   <= rev_d;
            err_onehot  <= eoh_d;
            err_seq     <= eseq_d;
            wrap_pulse  <= wrap_d;
            phase_valid <= (state_d == ST_LOCK);
            in_fault    <= (state_d == ST_FAULT);
        end
    end

    // Priority: clr_err, then FAULT hold, then en, then per-state sample checks.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        phase_d = phase;
        rev_d   = rev_count;
        eoh_d   = err_onehot;
        eseq_d  = err_seq;
        wrap_d  = 1'b0;
        if (clr_err) begin
            state_d = ST_IDLE;
            eoh_d   = 1'b0;
            eseq_d  = 1'b0;
        end else if (state_q != ST_FAULT) begin
            if (!en) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (hot_ok) begin
                            state_d = ST_LOCK;
                            prev_d  = q_in;
                            phase_d = hot_idx;
                        end
                    end
                    ST_LOCK: begin
                        if (!hot_ok) begin
                            state_d = ST_FAULT;
                            eoh_d   = 1'b1;
                        end else if (resync) begin
                            prev_d  = q_in;
                            phase_d = hot_idx;
                        end else if (q_in == exp_q) begin
                            prev_d  = q_in;
                            phase_d = hot_idx;
                            if (prev_q[WIDTH-1]) begin
                                wrap_d = 1'b1;
                                rev_d  = rev_count + REV_W'(1);
                            end
                        end else begin
                            state_d = ST_FAULT;
                            eseq_d  = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

endmodule
